// File: rtl/vg_trap.sv
// rtl/vg_trap.sv - VG93 port trap front end: access strobe, NMI request, emulation window
module vg_trap (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       dos,
   input  logic       in_trdemu,
   input  logic [3:0] fdd_mask,
   input  logic [7:0] a,
   input  logic [7:0] din,
   input  logic       iowr_stb,
   input  logic       iord_stb,
   input  logic       iord,
   output logic       vg_rdwr_fclk,
   output logic [1:0] vg_a,
   output logic       clr_nmi,
   output logic       nmi_req,
   output logic [7:0] dout,
   output logic       dout_oe
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  trap_a;
   logic        trap_wr;
   logic [7:0]  trap_data;
   logic        overrun;
   logic [7:0]  shadow [4];

   logic [1:0]  idx;
   logic        vgport;
   logic        acc;
   logic        trap;
   logic        shadow_port;
   logic        sel_stat;
   logic        sel_data;
   logic        sel_clr;

   assign idx         = a[6:5];
   assign vgport      = ~a[7] & (a[4:0] == 5'h1F);
   assign acc         = (iord_stb | iowr_stb) & dos & vgport;
   assign trap        = acc & ~in_trdemu & fdd_mask[idx];
   assign shadow_port = in_trdemu & ~a[7] & (a[4:0] == 5'h1E);
   assign sel_stat    = in_trdemu & (a == 8'h9E);
   assign sel_data    = in_trdemu & (a == 8'hDE);
   assign sel_clr     = in_trdemu & (a == 8'hBE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (trap)      state_nx = ST_PEND;
         ST_PEND:    if (in_trdemu) state_nx = ST_SERVICE;
         ST_SERVICE: if (clr_nmi)   state_nx = ST_IDLE;
         default:                   state_nx = ST_IDLE;
      endcase
   end

   // nmi_req is a flop of its own so it follows state edges without decode glitches
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         nmi_req <= 1'b0;
      end else begin
         state   <= state_nx;
         nmi_req <= (state_nx == ST_PEND);
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         trap_a    <= 2'd0;
         trap_wr   <= 1'b0;
         trap_data <= 8'h00;
         overrun   <= 1'b0;
      end else begin
         if (state == ST_IDLE && trap) begin
            trap_a    <= idx;
            trap_wr   <= iowr_stb;
            trap_data <= iowr_stb ? din : 8'h00;
         end
         if (clr_nmi)
            overrun <= 1'b0;
         else if (state == ST_PEND && trap)
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         vg_rdwr_fclk <= 1'b0;
         vg_a         <= 2'd0;
         clr_nmi      <= 1'b0;
         for (int i = 0; i < 4; i++) shadow[i] <= 8'h00;
      end else begin
         vg_rdwr_fclk <= acc;
         if (acc) vg_a <= idx;
         clr_nmi <= iowr_stb & sel_clr;
         if (iowr_stb && shadow_port) shadow[idx] <= din;
      end
   end

   always_comb begin
      dout    = 8'h00;
      dout_oe = 1'b0;
      if (iord) begin
         if (dos && vgport && fdd_mask[idx]) begin
            dout    = shadow[idx];
            dout_oe = 1'b1;
         end else if (sel_stat) begin
            dout    = {trap_wr, overrun, 4'b0000, trap_a};
            dout_oe = 1'b1;
         end else if (sel_data) begin
            dout    = trap_data;
            dout_oe = 1'b1;
         end
      end
   end

endmodule

// File: doc/vg_trap.md
Name: vg_trap

Overview:
- Front end of the WD1793 (VG93) emulation path.
- Watches CPU I/O cycles to the VG93 register ports while DOS is active. It produces the access strobe and register index that start emulation-RAM paging. It latches the trapped access and raises an NMI request.
- Gives the emulation code (running with in_trdemu=1) a small port window: trap status, captured write data, per-register shadow read values, and the #BE release strobe (clr_nmi).

Parameters:
- NONE_USED, n/a: no parameters; all port addresses are fixed.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  async reset, active-low
- dos  in  1  DOS ROM active
- in_trdemu  in  1  emulation page #FE mapped (returned by DOS control block)
- fdd_mask  in  4  bit n enables trapping of VG register n
- a  in  8  CPU address low byte
- din  in  8  CPU write data
- iowr_stb  in  1  one-fclk strobe per CPU I/O write
- iord_stb  in  1  one-fclk strobe per CPU I/O read
- iord  in  1  level: CPU I/O read cycle in progress
- vg_rdwr_fclk  out  1  registered one-cycle pulse per VG port access while dos=1
- vg_a  out  2  registered VG register index, valid with vg_rdwr_fclk
- clr_nmi  out  1  one-cycle pulse on emulation write to #BE
- nmi_req  out  1  NMI request to CPU
- dout  out  8  read data
- dout_oe  out  1  dout drives CPU bus

Behaviour:
- VG port decode: a[7]=0 and a[4:0]=5'h1F. Index is a[6:5], covering #1F/#3F/#5F/#7F. #FF is not decoded here.
- Access event: (iord_stb|iowr_stb) & dos & vgport.
  - Registered next cycle: vg_rdwr_fclk=1 and vg_a=a[6:5] for exactly one cycle.
  - vg_a holds its value afterwards.
- Trap condition: access event & !in_trdemu & fdd_mask[a[6:5]].
- FSM states:
  - IDLE → PEND on trap. Same edge latches trap_a=a[6:5], trap_wr=iowr_stb, trap_data=din (write) or 8'h00 (read), and sets nmi_req=1.
  - PEND → SERVICE when in_trdemu=1; nmi_req←0 on that edge.
  - SERVICE → IDLE on clr_nmi.
- Latency: trap strobe to nmi_req=1 is 1 cycle. in_trdemu rising to nmi_req=0 is 1 cycle.
- Overrun: a trap condition in PEND does not overwrite the latched values; it sets overrun=1. overrun clears on clr_nmi.
- No trap is possible in SERVICE, because the trap condition requires !in_trdemu.
- dos falling in PEND: no effect; nmi_req holds until in_trdemu.
- Emulation window, decoded only when in_trdemu=1:
  - Write #1E/#3E/#5E/#7E: shadow[a[6:5]]←din.
  - Read #9E: {trap_wr, overrun, 4'b0, trap_a}.
  - Read #DE: trap_data.
  - Write #BE: clr_nmi pulse, registered, one cycle after iowr_stb.
- CPU read of a VG port with dos=1 and fdd_mask[idx]=1:
  - dout=shadow[idx], dout_oe=1.
  - dout/dout_oe are combinational from iord & decode and are held for the whole iord level.
  - The read still traps if in_trdemu=0.
- dout_oe=0 otherwise; dout=8'h00 when not enabled.
- Simultaneous clr_nmi and in_trdemu still high: state goes IDLE. A trap requires in_trdemu low, so no conflict.
- Reset values: nmi_req=0, vg_rdwr_fclk=0, vg_a=0, clr_nmi=0, state IDLE, trap_a=0, trap_wr=0, trap_data=0, overrun=0, shadow[0..3]=0.
- Async reset mid-trap returns to IDLE immediately and drops nmi_req.

Test Plan:
- Setup dos=1, fdd_mask=4'b0001. Write #1F data 8'h08 → next cycle vg_rdwr_fclk=1, vg_a=0, nmi_req=1. After in_trdemu=1, read #9E=8'h80 and #DE=8'h08.
- Setup fdd_mask=4'b0000. Read #3F → vg_rdwr_fclk=1, vg_a=1, nmi_req stays 0, dout_oe=0.
- In SERVICE, write #5E=8'hA5 then #BE → clr_nmi one-cycle pulse, state IDLE. Set fdd_mask[2]=1, in_trdemu=0, read #5F → dout=8'hA5, dout_oe=1, and nmi_req=1 next cycle.
- In PEND, write #7F 8'h33 with mask 4'b1001 → trap_data keeps first value and overrun=1. In SERVICE, #9E bit6=1; it reads 0 after clr_nmi.
- dos=0, access #1F → no vg_rdwr_fclk, no trap. Separately, assert rst_n=0 while nmi_req=1 → nmi_req=0 immediately, all status registers read 0.
